// File: rtl/uart_tx_arb.sv
// uart_tx_arb
//   Round-robin arbiter and byte sequencer sharing one UART transmit path
//   among NREQ requesters. A requester keeps the transmitter for a whole
//   packet. Bytes are paced into the transmit controller with GAP idle cycles
//   after every accepted byte. The grant is released at packet end, on abort,
//   or after MAXLEN bytes.
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous reset, active low
//   req       per-requester request, held while a byte is offered
//   din       byte of requester i on din[8*i+7:8*i]
//   last      marks din of requester i as the final byte of its packet
//   ack       one-cycle pulse: owner's current byte was taken
//   grant     one-hot transmitter owner, all zero when idle
//   out_rdy   downstream can accept a byte
//   out_data  byte to the transmit controller
//   out_en    one-cycle write strobe to the transmit controller
//   busy      high whenever not idle
module uart_tx_arb #(
  parameter int NREQ   = 4,
  parameter int GAP    = 2,
  parameter int MAXLEN = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] din,
  input  logic [NREQ-1:0]   last,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   grant,
  input  logic              out_rdy,
  output logic [7:0]        out_data,
  output logic              out_en,
  output logic              busy
);

  localparam int PW = $clog2(NREQ);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t          state, state_n;
  logic [NREQ-1:0] grant_n, ack_n;
  logic [PW-1:0]   ptr, ptr_n;
  logic [7:0]      cnt, cnt_n;
  logic [GW-1:0]   gcnt, gcnt_n;
  logic            rel, rel_n;
  logic [7:0]      data_n;
  logic            en_n;

  logic [PW-1:0]   own;
  logic [7:0]      own_byte;
  logic [PW-1:0]   win;
  logic            found;

  // Owner index and its byte, decoded from the one-hot grant.
  always_comb begin
    own      = '0;
    own_byte = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        own      = PW'(i);
        own_byte = din[8*i +: 8];
      end
    end
  end

  // First requester at or above ptr+1, wrapping modulo NREQ.
  always_comb begin
    int unsigned idx;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!found && req[idx]) begin
        win   = PW'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant;
    ptr_n   = ptr;
    cnt_n   = cnt;
    gcnt_n  = gcnt;
    rel_n   = rel;
    data_n  = out_data;
    en_n    = 1'b0;
    ack_n   = '0;
    case (state)
      S_IDLE: begin
        grant_n = '0;
        if (found) begin
          grant_n[win] = 1'b1;
          cnt_n        = '0;
          rel_n        = 1'b0;
          state_n      = S_SEND;
        end
      end
      S_SEND: begin
        if (!(|(req & grant))) begin
          grant_n = '0;
          ptr_n   = own;
          state_n = S_IDLE;
        end else if (out_rdy) begin
          data_n  = own_byte;
          en_n    = 1'b1;
          ack_n   = grant;
          cnt_n   = cnt + 8'd1;
          gcnt_n  = GW'(GAP - 1);
          rel_n   = (|(last & grant)) || (cnt == 8'(MAXLEN - 1));
          state_n = S_GAP;
        end
      end
      S_GAP: begin
        if (gcnt == '0) begin
          if (rel) begin
            grant_n = '0;
            ptr_n   = own;
            state_n = S_IDLE;
          end else begin
            state_n = S_SEND;
          end
        end else begin
          gcnt_n = gcnt - GW'(1);
        end
      end
      default: begin
        grant_n = '0;
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      grant    <= '0;
      ack      <= '0;
      out_en   <= 1'b0;
      out_data <= '0;
      cnt      <= '0;
      gcnt     <= '0;
      rel      <= 1'b0;
      ptr      <= PW'(NREQ - 1);
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      ack      <= ack_n;
      out_en   <= en_n;
      out_data <= data_n;
      cnt      <= cnt_n;
      gcnt     <= gcnt_n;
      rel      <= rel_n;
      ptr      <= ptr_n;
    end
  end

  assign busy = (state != S_IDLE);

endmodule
